// File: rtl/arb_types.sv
`default_nettype none
// ============================================================================
// Module      : arb_types (package)
// Description : Shared types for the cache arbiter: the FSM state encoding
//               and the round-robin grant owner.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

endpackage : arb_types
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr_pick
// Description : Combinational two-way round-robin selector. A lone requester
//               always wins; on contention the side that did not win last
//               time is chosen.
// Ports       : req_i      - icache is requesting
//               req_d      - dcache is requesting
//               last_grant - owner of the most recent grant
//               valid      - at least one request present
//               grant      - selected owner (meaningful only when valid)
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_pick
    import arb_types::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  arb_grant_t last_grant,
    output logic       valid,
    output arb_grant_t grant
);

    always_comb begin
        valid = req_i | req_d;
        grant = GRANT_I;
        if (req_i && req_d) begin
            grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (req_d) begin
            grant = GRANT_D;
        end
    end

endmodule : arb_rr_pick
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Shares one physical-memory line port between the icache and
//               dcache. One request is granted at a time; its address, write
//               data and operation are latched at the grant edge and drive
//               memory until pmem_resp, which is routed combinationally back
//               to the owner. A one-cycle RECOVER state follows every
//               completion so the owner can drop its held request.
// Ports       : clk, rst (sync, active-low)
//               i_read/i_address -> i_rdata/i_resp      icache side
//               d_read/d_write/d_address/d_wdata
//                                -> d_rdata/d_resp      dcache side
//               pmem_read/pmem_write/pmem_address/pmem_wdata
//                                <- pmem_rdata/pmem_resp memory side
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    arb_grant_t        r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_op_write;

    logic              w_valid;
    arb_grant_t        w_grant;
    logic              w_take;
    logic              w_serving;

    arb_rr_pick u_pick (
        .req_i      (i_read),
        .req_d      (d_read | d_write),
        .last_grant (r_last_grant),
        .valid      (w_valid),
        .grant      (w_grant)
    );

    assign w_take = (r_state == IDLE) && w_valid;

    // State register and transaction latches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_I;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_op_write   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_take) begin
                r_last_grant <= w_grant;
                r_addr       <= (w_grant == GRANT_D) ? d_address : i_address;
                r_wdata      <= d_wdata;
                // A dcache request with both strobes high is treated as a write.
                r_op_write   <= (w_grant == GRANT_D) && d_write;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_next = (w_grant == GRANT_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    w_state_next = RECOVER;
                end
            end
            RECOVER: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_serving    = (r_state == SERVE_I) || (r_state == SERVE_D);
    assign pmem_read    = w_serving && !r_op_write;
    assign pmem_write   = w_serving && r_op_write;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;

    // Responses outside a SERVE state are dropped here.
    assign i_resp  = (r_state == SERVE_I) && pmem_resp;
    assign d_resp  = (r_state == SERVE_D) && pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    a_no_dual_dcache_op : assert property (
        @(posedge clk) disable iff (!rst) !(d_read && d_write)
    );

endmodule : cache_arbiter
`default_nettype wire
